// File: rtl/sram_pixel_writer.sv
// Buffers loader pixel writes in a small FIFO and commits them to the async
// frame-buffer SRAM, giving display reads fixed-latency priority over writes.
module sram_pixel_writer #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_load_fin,
  output logic              o_frame_done,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic [1:0]        dbg_state
);

  // Handshake: a pixel is taken on every rising edge where i_wr_valid and
  // o_wr_ready are both high; the producer holds its request until then.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, pop;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dq_d;
  logic              oe_n_d, we_n_d, dq_oe_d;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Ready comes from the registered count only, never from this cycle's pop.
  assign o_wr_ready = !avm_rst && !full;
  assign push       = i_wr_valid && o_wr_ready;
  assign pop        = (state_d == S_WRITE);

  always_ff @(posedge avm_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_wr_addr;
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    if (i_rd_req)    state_d = S_READ;
    else if (!empty) state_d = S_WRITE;
  end

  // Next values of the registered SRAM pins, keyed on the state being entered.
  always_comb begin
    addr_d  = o_sram_addr;
    dq_d    = o_sram_dq;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    unique case (state_d)
      S_READ: begin
        addr_d = i_rd_addr;
        oe_n_d = 1'b0;
      end
      S_WRITE: begin
        addr_d  = fifo_addr[rd_ptr];
        dq_d    = fifo_data[rd_ptr];
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
    end else begin
      o_sram_addr  <= addr_d;
      o_sram_dq    <= dq_d;
      o_sram_oe_n  <= oe_n_d;
      o_sram_we_n  <= we_n_d;
      o_sram_dq_oe <= dq_oe_d;
    end
  end

  // Read data is sampled at the close of the S_READ cycle.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= (state == S_READ);
      if (state == S_READ) o_rd_data <= i_sram_dq;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst || !i_load_fin)              o_frame_done <= 1'b0;
    else if (empty && (state != S_WRITE))    o_frame_done <= 1'b1;
  end

  assign o_sram_ce_n = 1'b0;
  assign o_sram_lb_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Directed bench for sram_pixel_writer: vector table for single writes/reads,
// hand-written sequences for FIFO fill, read priority, frame done and reset.
module tb_sram_pixel_writer;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int W  = AW + DW;

  logic          avm_clk = 1'b0;
  logic          avm_rst;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_load_fin;
  logic          o_frame_done;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_dq;
  logic          o_sram_dq_oe;
  logic [DW-1:0] i_sram_dq;
  logic          o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n;
  logic [1:0]    dbg_state;

  logic [DW-1:0] sram_q;
  // The SRAM only returns meaningful data while its output enable is low.
  assign i_sram_dq = o_sram_oe_n ? 16'hDEAD : sram_q;

  sram_pixel_writer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .avm_clk      (avm_clk),
    .avm_rst      (avm_rst),
    .i_wr_valid   (i_wr_valid),
    .o_wr_ready   (o_wr_ready),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_load_fin   (i_load_fin),
    .o_frame_done (o_frame_done),
    .i_rd_req     (i_rd_req),
    .i_rd_addr    (i_rd_addr),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_sram_addr  (o_sram_addr),
    .o_sram_dq    (o_sram_dq),
    .o_sram_dq_oe (o_sram_dq_oe),
    .i_sram_dq    (i_sram_dq),
    .o_sram_ce_n  (o_sram_ce_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_lb_n  (o_sram_lb_n),
    .o_sram_ub_n  (o_sram_ub_n),
    .dbg_state    (dbg_state)
  );

  always #5 avm_clk = ~avm_clk;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int wcnt;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge avm_clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit took;
    int n;
    took = 1'b0;
    n = 0;
    i_wr_valid = 1'b1;
    i_wr_addr  = a;
    i_wr_data  = d;
    while (!took && n < 200) begin
      @(negedge avm_clk);
      took = o_wr_ready;
      @(posedge avm_clk);
      #1;
      n++;
    end
    i_wr_valid = 1'b0;
    if (took) begin
      exp_q.push_back({a, d});
      n_acc++;
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_accepted required=accepted addr=%0h", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge avm_clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Scoreboard: every SRAM write cycle must match the oldest accepted pixel.
  always @(negedge avm_clk) begin
    if (o_sram_we_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_write actual=%0h required=no_write", {o_sram_addr, o_sram_dq});
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_order", 64'({o_sram_addr, o_sram_dq}), 64'(mon_e));
        chk("write_ctl", 64'({o_sram_dq_oe, o_sram_oe_n}), 64'b11);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 20'h00005, 16'hF81F, 20'h00005, 16'hF81F};
    vecs[1] = '{1'b0, 20'hFFFFF, 16'h1234, 20'hFFFFF, 16'h1234};
    vecs[2] = '{1'b1, 20'h12345, 16'h07E0, 20'h12345, 16'h07E0};
    vecs[3] = '{1'b0, 20'h00000, 16'hFFFF, 20'h00000, 16'hFFFF};
    vecs[4] = '{1'b1, 20'hFFFFF, 16'hA5A5, 20'hFFFFF, 16'hA5A5};
    vecs[5] = '{1'b1, 20'h00000, 16'h0001, 20'h00000, 16'h0001};
    vecs[6] = '{1'b0, 20'hABCDE, 16'h0000, 20'hABCDE, 16'h0000};

    avm_rst    = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_addr  = '0;
    i_wr_data  = '0;
    i_load_fin = 1'b0;
    i_rd_req   = 1'b0;
    i_rd_addr  = '0;
    sram_q     = '0;

    // Reset values
    tick();
    @(negedge avm_clk);
    chk("rst_ready", 64'(o_wr_ready), 64'd0);
    chk("rst_done", 64'(o_frame_done), 64'd0);
    chk("rst_rd", 64'({o_rd_valid, o_rd_data}), 64'd0);
    chk("rst_bus", 64'({o_sram_addr, o_sram_dq, o_sram_dq_oe}), 64'd0);
    chk("rst_ctl", 64'({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}), 64'b01100);
    tick();
    avm_rst = 1'b0;
    tick();
    @(negedge avm_clk);
    chk("post_rst", 64'({o_wr_ready, o_sram_oe_n, o_sram_we_n}), 64'b111);
    tick();

    // Table of single writes and single reads
    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].is_rd) begin
        push(vecs[i].addr, vecs[i].data);
        @(negedge avm_clk);
        chk("vec_wr_pre", 64'(o_sram_we_n), 64'd1);
        @(negedge avm_clk);
        chk("vec_wr_bus", 64'({o_sram_we_n, o_sram_dq_oe, o_sram_addr, o_sram_dq}),
            64'({1'b0, 1'b1, vecs[i].exp_addr, vecs[i].exp_data}));
        @(negedge avm_clk);
        chk("vec_wr_idle", 64'({o_sram_we_n, o_sram_oe_n, o_sram_dq_oe, o_sram_addr}),
            64'({1'b1, 1'b1, 1'b0, vecs[i].exp_addr}));
      end else begin
        i_rd_req  = 1'b1;
        i_rd_addr = vecs[i].addr;
        sram_q    = vecs[i].data;
        tick();
        i_rd_req  = 1'b0;
        i_rd_addr = '0;
        @(negedge avm_clk);
        chk("vec_rd_bus", 64'({o_sram_oe_n, o_sram_we_n, o_sram_dq_oe, o_sram_addr}),
            64'({1'b0, 1'b1, 1'b0, vecs[i].exp_addr}));
        chk("vec_rd_state", 64'(dbg_state), 64'd1);
        chk("vec_rd_early", 64'(o_rd_valid), 64'd0);
        @(negedge avm_clk);
        chk("vec_rd_data", 64'({o_rd_valid, o_rd_data}), 64'({1'b1, vecs[i].exp_data}));
        @(negedge avm_clk);
        chk("vec_rd_pulse", 64'(o_rd_valid), 64'd0);
      end
      tick();
    end

    // Read priority over two pending writes
    i_wr_valid = 1'b1;
    i_wr_addr  = 20'h00A01;
    i_wr_data  = 16'h1111;
    tick();
    exp_q.push_back({20'h00A01, 16'h1111});
    i_wr_addr  = 20'h00A02;
    i_wr_data  = 16'h2222;
    i_rd_req   = 1'b1;
    i_rd_addr  = 20'h12345;
    sram_q     = 16'h07E0;
    tick();
    exp_q.push_back({20'h00A02, 16'h2222});
    i_wr_valid = 1'b0;
    i_rd_req   = 1'b0;
    @(negedge avm_clk);
    chk("prio_read_cyc", 64'({o_sram_oe_n, o_sram_we_n, o_sram_addr}), 64'({1'b0, 1'b1, 20'h12345}));
    @(negedge avm_clk);
    chk("prio_rd_data", 64'({o_rd_valid, o_rd_data}), 64'({1'b1, 16'h07E0}));
    chk("prio_wr_after", 64'(o_sram_we_n), 64'd0);
    drain();

    // FIFO fills under continuous reads, then drains without gaps
    i_rd_req  = 1'b1;
    i_rd_addr = 20'h00100;
    sram_q    = 16'h3C3C;
    n_acc     = 0;
    fork
      begin
        for (int n = 0; n < 6; n++) push(AW'(n), 16'hA000 + DW'(n));
      end
      begin
        repeat (12) @(negedge avm_clk);
        chk("full_ready", 64'(o_wr_ready), 64'd0);
        chk("full_accepted", 64'(n_acc), 64'd4);
        tick();
        i_rd_req = 1'b0;
        @(negedge avm_clk);
        wcnt = 0;
        repeat (6) begin
          @(negedge avm_clk);
          if (o_sram_we_n === 1'b0) wcnt++;
        end
        chk("drain_no_gap", 64'(wcnt), 64'd6);
      end
    join
    drain();

    // Frame done waits for the last buffered write
    i_rd_req  = 1'b1;
    i_rd_addr = 20'h00200;
    for (int n = 0; n < 3; n++) push(20'h00300 + AW'(n), 16'hB000 + DW'(n));
    i_load_fin = 1'b1;
    @(negedge avm_clk);
    chk("fd_pending", 64'(o_frame_done), 64'd0);
    tick();
    i_rd_req = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge avm_clk);
      chk("fd_wait", 64'(o_frame_done), 64'd0);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge avm_clk);
      chk("fd_hold", 64'(o_frame_done), 64'd1);
    end
    tick();
    i_load_fin = 1'b0;
    @(negedge avm_clk);
    chk("fd_sticky", 64'(o_frame_done), 64'd1);
    @(negedge avm_clk);
    chk("fd_clear", 64'(o_frame_done), 64'd0);
    tick();

    // Reset in the middle of a write burst
    i_rd_req  = 1'b1;
    i_rd_addr = 20'h00500;
    for (int n = 0; n < 3; n++) push(20'h00400 + AW'(n), 16'hC000 + DW'(n));
    tick();
    i_rd_req = 1'b0;
    tick();
    avm_rst = 1'b1;
    @(negedge avm_clk);
    chk("mid_write_seen", 64'(o_sram_we_n), 64'd0);
    tick();
    exp_q.delete();
    @(negedge avm_clk);
    chk("mid_rst_bus", 64'({o_sram_we_n, o_sram_dq_oe, o_wr_ready}), 64'b100);
    tick();
    avm_rst = 1'b0;
    wcnt = 0;
    repeat (6) begin
      @(negedge avm_clk);
      if (o_sram_we_n === 1'b0) wcnt++;
    end
    chk("no_stale_write", 64'(wcnt), 64'd0);
    chk("post_mid_ready", 64'(o_wr_ready), 64'd1);
    tick();

    // Writer still works after the abort
    push(20'h0BEEF, 16'h5555);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
